traffic_light_multi: RTL

- Parametrised N-direction traffic-light controller; successor to the two-road (A/B) controller with parade mode.
- Grants green to one direction at a time with round-robin service, sensor-based skip and extension, timed minimum-green and yellow phases, and a parade mode that pins one configurable direction green.
- Sits at the top of the intersection-control path; drives lamp encodings directly.

---
 rtl/traffic_light_multi.sv | 104 ++++++++++
 1 files changed

// File: rtl/traffic_light_multi.sv
// N-direction traffic-light controller: round-robin green with sensor skip/extension,
// timed minimum-green and yellow phases, and a parade mode pinning one direction green.

module traffic_lamp (
    input  logic       sel,
    input  logic       yellow,
    output logic [1:0] lamp
);
    assign lamp = !sel ? 2'b00 : (yellow ? 2'b01 : 2'b10);
endmodule

module traffic_light_multi #(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int PARADE_DIR = 0,
    parameter int CNT_W      = 8,
    parameter int DIR_W      = $clog2(N_DIR)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_DIR-1:0]   t,
    input  logic               p,
    input  logic               r,
    output logic [2*N_DIR-1:0] light,
    output logic [DIR_W-1:0]   cur_dir,
    output logic               parade_active,
    output logic               dir_change
);
    typedef enum logic {GREEN, YELLOW} state_t;

    state_t                       state;
    logic   [CNT_W-1:0]           cnt;
    logic                         mode;
    logic                         hold;
    logic   [DIR_W-1:0]           next_dir;
    logic   [N_DIR-1:0][1:0]      lamps;

    assign parade_active = mode;

    always_comb begin
        hold = mode ? (cur_dir == DIR_W'(PARADE_DIR)) : t[cur_dir];
    end

    // Plain rotation unless another direction is waiting; parade overrides both.
    always_comb begin
        logic found;
        found    = 1'b0;
        next_dir = (cur_dir == DIR_W'(N_DIR-1)) ? '0 : cur_dir + DIR_W'(1);
        for (int k = 1; k < N_DIR; k++) begin
            int idx;
            idx = (int'(cur_dir) + k) % N_DIR;
            if (!found && t[idx]) begin
                next_dir = DIR_W'(idx);
                found    = 1'b1;
            end
        end
        if (mode) next_dir = DIR_W'(PARADE_DIR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= GREEN;
            cur_dir    <= '0;
            cnt        <= '0;
            mode       <= 1'b0;
            dir_change <= 1'b0;
        end else begin
            dir_change <= 1'b0;
            if (r)      mode <= 1'b0;
            else if (p) mode <= 1'b1;
            if (state == GREEN) begin
                // Counter saturates so an extended green leaves as soon as hold drops.
                if (cnt == CNT_W'(GREEN_CYC-1)) begin
                    if (!hold) begin
                        state <= YELLOW;
                        cnt   <= '0;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                if (cnt == CNT_W'(YELLOW_CYC-1)) begin
                    state      <= GREEN;
                    cnt        <= '0;
                    cur_dir    <= next_dir;
                    dir_change <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
        traffic_lamp u_lamp (
            .sel    (cur_dir == DIR_W'(i)),
            .yellow (state == YELLOW),
            .lamp   (lamps[i])
        );
    end

    assign light = lamps;
endmodule
